// File: rtl/edp_fp_pkg.sv
// rtl/edp_fp_pkg.sv - IEEE-754 single constants and unpacked product type shared with the multiplier path
package edp_fp_pkg;

  localparam int FP_BIAS     = 127;
  localparam int FP_EXP_MAX  = 255;
  localparam int FP_EXP_W    = 8;
  localparam int FP_FRAC_W   = 23;
  localparam int FP_SIG_W    = FP_FRAC_W + 1;
  localparam int PROD_EXP_W  = 10;
  localparam int PROD_MANT_W = 48;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_INF  = 32'h7F80_0000;

  typedef struct packed {
    logic                   sign;
    logic [PROD_EXP_W-1:0]  exponent;
    logic [PROD_MANT_W-1:0] mantissa;
  } unpacked_fp_t;

endpackage

// File: rtl/lzc48.sv
// rtl/lzc48.sv - combinational 48-bit leading-zero counter with all-zero flag
module lzc48 (
  input  logic [47:0] value,
  output logic [5:0]  count,
  output logic        all_zero
);

  // Ascending scan: the highest set bit is the last one to write the count.
  always_comb begin
    count = 6'd48;
    for (int i = 0; i < 48; i++) begin
      if (value[i]) count = 6'(47 - i);
    end
  end

  assign all_zero = (value == '0);

endmodule

// File: rtl/exact_fp_pack.sv
// rtl/exact_fp_pack.sv - normalize, round (RNE) and pack an exact product into IEEE-754 single
module exact_fp_pack
  import edp_fp_pkg::*;
#(
  parameter int IN_EXP_WIDTH      = 10,
  parameter int IN_MANTISSA_WIDTH = 48,
  parameter int DATA_WIDTH        = 32
) (
  input  logic                         Clk,
  input  logic                         ResetN,
  input  logic                         InValid,
  output logic                         InReady,
  input  logic                         InSign,
  input  logic [IN_EXP_WIDTH-1:0]      InExponent,
  input  logic [IN_MANTISSA_WIDTH-1:0] InMantissa,
  output logic                         OutValid,
  input  logic                         OutReady,
  output logic [DATA_WIDTH-1:0]        OutData
);

  localparam int EW = IN_EXP_WIDTH + 1;
  localparam int MW = IN_MANTISSA_WIDTH;

  logic advance;
  assign advance = !OutValid || OutReady;
  assign InReady = advance;

  // S1: leading-zero count
  logic [5:0]    lz_count;
  logic          lz_zero;
  logic          s1_valid, s1_sign, s1_zero;
  logic [EW-1:0] s1_exp;
  logic [MW-1:0] s1_mant;
  logic [5:0]    s1_lz;

  lzc48 u_lzc (
    .value    (InMantissa),
    .count    (lz_count),
    .all_zero (lz_zero)
  );

  // S2: shift and exponent adjust
  logic [MW-1:0] norm;
  logic          shifted_out;
  logic [EW-1:0] exp_norm;
  logic          s2_valid, s2_sign, s2_zero, s2_guard, s2_sticky;
  logic [EW-1:0] s2_exp;
  logic [FP_SIG_W-1:0] s2_sig;

  always_comb begin
    norm        = s1_mant;
    shifted_out = 1'b0;
    exp_norm    = s1_exp;
    if (s1_mant[MW-1]) begin
      norm        = s1_mant >> 1;
      shifted_out = s1_mant[0];
      exp_norm    = s1_exp + EW'(1);
    end else begin
      norm     = s1_mant << (s1_lz - 6'd1);
      exp_norm = s1_exp - EW'(s1_lz) + EW'(1);
    end
  end

  // S3: round to nearest even, then classify the final exponent
  logic                round_up;
  logic [FP_SIG_W:0]   sig_rnd;
  logic [EW-1:0]       exp_fin;
  logic [FP_FRAC_W-1:0] frac_fin;
  logic [DATA_WIDTH-1:0] packed_res;

  always_comb begin
    round_up = s2_guard & (s2_sticky | s2_sig[0]);
    sig_rnd  = {1'b0, s2_sig} + (FP_SIG_W+1)'(round_up);
    exp_fin  = s2_exp;
    frac_fin = sig_rnd[FP_FRAC_W-1:0];
    if (sig_rnd[FP_SIG_W]) begin
      frac_fin = sig_rnd[FP_FRAC_W:1];
      exp_fin  = s2_exp + EW'(1);
    end
    if (s2_zero)
      packed_res = {s2_sign, FP_ZERO[30:0]};
    else if (!exp_fin[EW-1] && exp_fin >= EW'(FP_EXP_MAX))
      packed_res = {s2_sign, FP_INF[30:0]};
    else if (exp_fin[EW-1] || exp_fin == '0)
      packed_res = {s2_sign, FP_ZERO[30:0]};
    else
      packed_res = {s2_sign, exp_fin[FP_EXP_W-1:0], frac_fin};
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      OutValid <= 1'b0;
      OutData  <= '0;
    end else if (advance) begin
      s1_valid <= InValid;
      s2_valid <= s1_valid;
      OutValid <= s2_valid;
      if (s2_valid) OutData <= packed_res;
    end
  end

  // Datapath stages only matter alongside their valid bit, so they carry no reset.
  always_ff @(posedge Clk) begin
    if (advance) begin
      s1_sign   <= InSign;
      s1_exp    <= {InExponent[IN_EXP_WIDTH-1], InExponent};
      s1_mant   <= InMantissa;
      s1_lz     <= lz_count;
      s1_zero   <= lz_zero;
      s2_sign   <= s1_sign;
      s2_zero   <= s1_zero;
      s2_exp    <= exp_norm;
      s2_sig    <= norm[MW-2 -: FP_SIG_W];
      s2_guard  <= norm[MW-2-FP_SIG_W];
      s2_sticky <= (|norm[MW-3-FP_SIG_W:0]) | shifted_out;
    end
  end

endmodule

// File: tb/tb_exact_fp_pack.sv
// tb/tb_exact_fp_pack.sv - self-checking bench for exact_fp_pack
module tb_exact_fp_pack;

  logic        Clk, ResetN, InValid, InReady, InSign, OutValid, OutReady;
  logic [9:0]  InExponent;
  logic [47:0] InMantissa;
  logic [31:0] OutData;

  exact_fp_pack #(
    .IN_EXP_WIDTH      (10),
    .IN_MANTISSA_WIDTH (48),
    .DATA_WIDTH        (32)
  ) dut (
    .Clk        (Clk),
    .ResetN     (ResetN),
    .InValid    (InValid),
    .InReady    (InReady),
    .InSign     (InSign),
    .InExponent (InExponent),
    .InMantissa (InMantissa),
    .OutValid   (OutValid),
    .OutReady   (OutReady),
    .OutData    (OutData)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int          tests = 0;
  int          fails = 0;
  int          popped = 0;
  logic [31:0] exp_q[$];
  logic        prev_hold = 1'b0;
  logic [31:0] prev_data = '0;

  typedef struct {
    logic        sign;
    int          exponent;
    logic [47:0] mant;
    logic [31:0] want;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, want);
    end
  endtask

  // Reference: value = m * 2^(E-127-46); locate the MSB, keep 24 bits, RNE on the rest.
  function automatic logic [31:0] ref_pack(input logic s, input logic [9:0] e_in, input logic [47:0] m);
    int p, e;
    longint unsigned mm, sig, rem, half;
    if (m == '0) return {s, 31'b0};
    mm = 64'(m);
    p  = 0;
    for (int i = 0; i < 48; i++) if (m[i]) p = i;
    e = int'($signed(e_in)) + p - 46;
    if (p > 23) begin
      sig  = mm >> (p - 23);
      rem  = mm - (sig << (p - 23));
      half = 64'd1 << (p - 24);
      if (rem > half || (rem == half && sig[0])) sig = sig + 1;
    end else begin
      sig = mm << (23 - p);
    end
    if (sig == (64'd1 << 24)) begin
      sig = sig >> 1;
      e   = e + 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'b0};
    if (e <= 0) return {s, 31'b0};
    return {s, 8'(e), sig[22:0]};
  endfunction

  task automatic step(input logic iv, input logic s, input logic [9:0] e, input logic [47:0] m,
                      input logic ordy, output logic acc);
    @(negedge Clk);
    InValid = iv; InSign = s; InExponent = e; InMantissa = m; OutReady = ordy;
    #1;
    if (prev_hold) begin
      check("hold_valid", OutValid, 1);
      check("hold_data", OutData, prev_data);
    end
    check("in_ready", InReady, !OutValid || OutReady);
    if (OutValid && OutReady) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_out: got %08h, required no result", OutData);
      end else begin
        check("sb_data", OutData, exp_q.pop_front());
        popped++;
      end
    end
    acc = InValid && InReady;
    if (acc) exp_q.push_back(ref_pack(s, e, m));
    prev_hold = OutValid && !OutReady;
    prev_data = OutData;
  endtask

  task automatic idle(input logic ordy);
    logic a;
    step(1'b0, 1'b0, '0, '0, ordy, a);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    logic acc;
    logic [47:0] bm[6];
    int idx, pop0, stale;
    logic saw_block;

    vecs[0]  = '{1'b0, 127, 48'h400000000000, 32'h3F800000};
    vecs[1]  = '{1'b0, 127, 48'h900000000000, 32'h40100000};
    vecs[2]  = '{1'b0, 127, 48'h400000400000, 32'h3F800000};
    vecs[3]  = '{1'b0, 127, 48'h400000C00000, 32'h3F800002};
    vecs[4]  = '{1'b1, 127, 48'h000000000000, 32'h80000000};
    vecs[5]  = '{1'b0, 300, 48'h400000000000, 32'h7F800000};
    vecs[6]  = '{1'b0, 0,   48'h400000000000, 32'h00000000};
    vecs[7]  = '{1'b0, 253, 48'h7FFFFFC00000, 32'h7F000000};
    vecs[8]  = '{1'b0, 254, 48'h7FFFFFC00000, 32'h7F800000};
    vecs[9]  = '{1'b1, -5,  48'h400000000000, 32'h80000000};
    vecs[10] = '{1'b0, 127, 48'h000000000001, 32'h28800000};
    vecs[11] = '{1'b1, 127, 48'h400000000000, 32'hBF800000};
    vecs[12] = '{1'b0, 1,   48'h400000000000, 32'h00800000};
    vecs[13] = '{1'b0, 127, 48'hFFFFFFFFFFFF, 32'h40800000};

    ResetN = 1'b0; InValid = 1'b0; InSign = 1'b0; InExponent = '0; InMantissa = '0; OutReady = 1'b0;
    repeat (3) @(negedge Clk);
    check("reset_outvalid", OutValid, 0);
    check("reset_outdata", OutData, 0);
    ResetN = 1'b1;
    #1;
    check("reset_inready", InReady, 1);

    // Directed vectors, each checked for exact 3-cycle latency
    for (int i = 0; i < 14; i++) begin
      step(1'b1, vecs[i].sign, 10'(vecs[i].exponent), vecs[i].mant, 1'b1, acc);
      check($sformatf("vec%0d_accept", i), acc, 1);
      for (int k = 1; k <= 3; k++) begin
        idle(1'b1);
        check($sformatf("vec%0d_valid_c%0d", i, k), OutValid, k == 3);
        if (k == 3) check($sformatf("vec%0d_data", i), OutData, vecs[i].want);
      end
    end

    // Randomized traffic with random backpressure
    for (int c = 0; c < 400; c++) begin
      logic [47:0] m;
      logic [9:0]  e;
      m = {16'($urandom), 32'($urandom)} >> $urandom_range(0, 47);
      if ($urandom_range(0, 15) == 0) m = '0;
      e = 10'($urandom_range(0, 420)) - 10'd80;
      step($urandom_range(0, 3) != 0, 1'($urandom), e, m, $urandom_range(0, 3) != 0, acc);
    end
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) idle(1'b1);
    check("random_drained", exp_q.size(), 0);

    // Six beats against a five-cycle downstream stall
    for (int j = 0; j < 6; j++) bm[j] = 48'h400000000000 | (48'(j + 1) << 30);
    idx = 0; pop0 = popped; saw_block = 1'b0;
    for (int c = 0; c < 40 && !(idx == 6 && exp_q.size() == 0); c++) begin
      step(idx < 6, 1'b0, 10'(100 + idx), bm[idx < 6 ? idx : 0], c >= 5, acc);
      if (!InReady) saw_block = 1'b1;
      if (acc) idx++;
    end
    check("stall_inready_dropped", saw_block, 1);
    check("stall_all_sent", idx, 6);
    check("stall_results", popped - pop0, 6);

    // Reset with three beats in flight
    for (int j = 0; j < 3; j++) step(1'b1, 1'b0, 10'd127, bm[j], 1'b1, acc);
    InValid = 1'b0;
    @(posedge Clk);
    #2;
    check("pre_rst_valid", OutValid, 1);
    ResetN = 1'b0;
    #1;
    check("rst_outvalid", OutValid, 0);
    check("rst_outdata", OutData, 0);
    exp_q.delete();
    prev_hold = 1'b0;
    repeat (2) @(negedge Clk);
    ResetN = 1'b1;
    stale = 0;
    for (int c = 0; c < 6; c++) begin
      idle(1'b1);
      if (OutValid) stale++;
    end
    check("no_stale_after_rst", stale, 0);
    pop0 = popped;
    step(1'b1, 1'b1, 10'd128, 48'h400000000000, 1'b1, acc);
    for (int k = 1; k <= 3; k++) idle(1'b1);
    check("post_rst_data", OutData, 32'hC0000000);
    check("post_rst_count", popped - pop0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/exact_fp_pack.md
EXACT_FP_PACK -- requirements
Module: exact_fp_pack

Interface
REQ-001 SHALL have parameter IN_EXP_WIDTH, default 10, meaning width of the signed biased input exponent.
REQ-002 SHALL have parameter IN_MANTISSA_WIDTH, default 48, meaning width of the exact unnormalized input mantissa.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, meaning width of the packed IEEE-754 single output.
REQ-004 SHALL use one clock, Clk, and an asynchronous, active-low reset, ResetN.
REQ-005 Ports (name  direction  width  meaning):
 Clk  in  1  clock, rising edge
 ResetN  in  1  async active-low reset
 InValid  in  1  input beat valid
 InReady  out  1  block accepts beat
 InSign  in  1  product sign
 InExponent  in  IN_EXP_WIDTH  two's-complement biased exponent (E1+E2-127 convention)
 InMantissa  in  IN_MANTISSA_WIDTH  exact product, binary point between bits 46 and 45
 OutValid  out  1  packed result valid
 OutReady  in  1  downstream accepts result
 OutData  out  DATA_WIDTH  packed IEEE-754 single

Function
REQ-006 SHALL be a 3-stage pipeline: S1 leading-zero count, S2 shift plus exponent adjust, S3 round plus pack; latency exactly 3 cycles from accepted input to OutValid with no stalls.
REQ-007 SHALL advance all stages when advance = !OutValid || OutReady; InReady SHALL equal advance; a beat transfers only when InValid && InReady.
REQ-008 SHALL hold OutValid and OutData stable while OutValid && !OutReady; there SHALL be no loss, duplication or reordering; throughput SHALL be 1 result per cycle when unstalled.
REQ-009 SHALL normalize as follows: bit 47 set: shift right 1, exponent +1; otherwise, with lz = leading zeros of the 48-bit mantissa: shift left lz-1, exponent -(lz-1).
REQ-010 SHALL keep normalized bits 46:23 (hidden plus 23 fraction bits), use bit 22 as guard, and OR of bits 21:0 plus any right-shifted-out bit as sticky.
REQ-011 SHALL round to nearest, ties to even; on a rounding carry out of the 24-bit significand it SHALL shift right 1 and increment the exponent.
REQ-012 SHALL output signed zero {InSign, 31'b0} when InMantissa == 0, regardless of InExponent.
REQ-013 SHALL output signed infinity {InSign, 8'hFF, 23'b0} when the final biased exponent is >= 255, including overflow caused by rounding.
REQ-014 SHALL flush to signed zero when the final biased exponent is <= 0; no subnormal outputs and no NaN outputs are produced.
REQ-015 SHALL compute exponent arithmetic at IN_EXP_WIDTH+1 signed bits; intermediate values SHALL NOT wrap.

Reset
REQ-016 On ResetN low, all stage valid bits and OutValid SHALL clear asynchronously, and OutData SHALL reset to 0.
REQ-017 A reset asserted mid-operation SHALL discard all in-flight beats; the first OutValid after release SHALL come from a beat accepted after release.
REQ-018 Datapath registers other than OutData need no reset.

Structure
REQ-019 Package edp_fp_pkg SHALL hold FP_BIAS=127, FP_EXP_MAX=255, the IEEE field widths, the zero and infinity encodings, and typedef unpacked_fp_t {sign, exponent, mantissa}, shared with the multiplier path.
REQ-020 Leading-zero counting SHALL be a sub-module, lzc48 (combinational, 48-bit in, 6-bit count, all-zero flag).

Verification
REQ-021 Sign 0, Exp 127, Mant 1<<46 -> OutData 0x3F800000 exactly 3 cycles later.
REQ-022 Sign 0, Exp 127, Mant 0x900000000000 (1.5*1.5) -> 0x40100000.
REQ-023 Exp 127: Mant (1<<46)|(1<<22) -> 0x3F800000 (tie to even); Mant (1<<46)|(1<<23)|(1<<22) -> 0x3F800002.
REQ-024 Sign 1, Mant 0 -> 0x80000000; Exp 300, Mant 1<<46 -> 0x7F800000; Exp 0, Mant 1<<46 -> 0x00000000.
REQ-025 Stream 6 beats with OutReady low for 5 cycles -> InReady drops, all 6 results appear in order, and OutData is stable during the stall.
REQ-026 Assert ResetN low with 3 beats in flight -> OutValid is 0 immediately, and no stale result appears after release.
